// File: rtl/fft_input_pairer_if.sv
`default_nettype none
//============================================================================
// Module      : fft_input_pairer_pkg / fft_input_pairer_if
// Description : Sample type shared by the pairer and its neighbours, plus
//               the bus interface that bundles the pairer's input
//               handshake and FFT-facing output signals.
//               master : drives in_valid/in_sof/in_data, observes the rest
//               slave  : the pairer itself
// Revision    : 1.0 - initial release
//============================================================================
package fft_input_pairer_pkg;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_product_t;
endpackage

interface fft_input_pairer_if;
    import fft_input_pairer_pkg::*;

    logic             in_valid;
    logic             in_sof;
    complex_product_t in_data;
    logic             in_ready;
    complex_product_t data_0;
    complex_product_t data_1;
    logic             out_enable;
    logic             out_sof;
    logic             err_sof;

    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, data_0, data_1, out_enable, out_sof, err_sof
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, data_0, data_1, out_enable, out_sof, err_sof
    );
endinterface
`default_nettype wire

// File: rtl/fft_input_pairer.sv
`default_nettype none
//============================================================================
// Module      : fft_input_pairer
// Description : Buffers N-sample frames in a two-bank ping-pong memory and
//               replays each frame as N/2 pairs (x[k], x[k+N/2]) on
//               consecutive cycles, the first-stage butterfly order of the
//               radix-2 pipelined FFT.
// Ports       : clk        - clock
//               reset      - synchronous, active-high reset
//               bus.in_*   - sample input with valid/ready handshake;
//                            in_sof realigns the write pointer
//               bus.data_0 / data_1 / out_enable / out_sof
//                          - pair output, no backpressure
//               bus.err_sof- sticky flag: in_sof arrived mid-frame
// Revision    : 1.0 - initial release
//============================================================================
module fft_input_pairer
    import fft_input_pairer_pkg::*;
#(
    parameter int N       = 8,
    parameter int OUT_GAP = 0
) (
    input  logic              clk,
    input  logic              reset,
    fft_input_pairer_if.slave bus
);

    localparam int AW       = $clog2(N);
    localparam int KW       = AW - 1;
    localparam int GW       = (OUT_GAP > 1) ? $clog2(OUT_GAP) : 1;
    localparam int GAP_LAST = (OUT_GAP > 0) ? OUT_GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Ping-pong storage; contents are don't-care after reset.
    complex_product_t mem_q [2][N];

    logic [AW-1:0]    wr_cnt_q;
    logic             wr_bank_q;
    logic             err_q;
    logic [1:0]       bank_full_q, bank_full_d;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_release;

    complex_product_t data_0_q, data_1_q;
    logic             out_enable_q, out_sof_q;

    logic             in_ready;
    logic             accept;
    logic             resync;
    logic             frame_done;
    logic [AW-1:0]    wr_addr;

    //------------------------------------------------------------------
    // Writer
    //------------------------------------------------------------------
    // Ready depends only on registered state, never on in_valid.
    assign in_ready   = !bank_full_q[wr_bank_q];
    assign accept     = bus.in_valid && in_ready;
    // A mid-frame SOF throws away the partial frame and restarts at index 0.
    assign resync     = accept && bus.in_sof && (wr_cnt_q != '0);
    assign wr_addr    = resync ? '0 : wr_cnt_q;
    assign frame_done = accept && !resync && (wr_cnt_q == AW'(N - 1));

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_bank_q][wr_addr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            if (resync) begin
                wr_cnt_q <= AW'(1);
                err_q    <= 1'b1;
            end else if (frame_done) begin
                wr_cnt_q  <= '0;
                wr_bank_q <= ~wr_bank_q;
            end else begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    // Writer sets and reader clears always target different banks: the
    // writer only touches a non-full bank, the reader only a full one.
    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_release) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
        if (frame_done) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
    end

    //------------------------------------------------------------------
    // Reader FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            gap_q       <= '0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            gap_q       <= gap_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        gap_d      = gap_q;
        rd_bank_d  = rd_bank_q;
        rd_release = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = S_EMIT;
                    k_d     = '0;
                end
            end
            S_EMIT: begin
                k_d = k_q + 1'b1;
                if (k_q == KW'(N / 2 - 1)) begin
                    rd_release = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    k_d        = '0;
                    if (OUT_GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else if (bank_full_q[~rd_bank_q]) begin
                        // Other bank already waiting: chain frames with no idle cycle.
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_LAST)) begin
                    state_d = bank_full_q[rd_bank_q] ? S_EMIT : S_IDLE;
                    k_d     = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Registered pair outputs; data holds its last value outside EMIT.
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            data_0_q     <= '0;
            data_1_q     <= '0;
            out_enable_q <= 1'b0;
            out_sof_q    <= 1'b0;
        end else begin
            out_enable_q <= (state_q == S_EMIT);
            out_sof_q    <= (state_q == S_EMIT) && (k_q == '0);
            if (state_q == S_EMIT) begin
                data_0_q <= mem_q[rd_bank_q][{1'b0, k_q}];
                data_1_q <= mem_q[rd_bank_q][{1'b1, k_q}];
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.data_0     = data_0_q;
    assign bus.data_1     = data_1_q;
    assign bus.out_enable = out_enable_q;
    assign bus.out_sof    = out_sof_q;
    assign bus.err_sof    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_input_pairer.sv
`default_nettype none
//============================================================================
// Module      : tb_fft_input_pairer
// Description : Bench for fft_input_pairer. Two instances (OUT_GAP=0 and
//               OUT_GAP=12) share one stimulus driver; a frame-level model
//               predicts every output cycle of both.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fft_input_pairer;
    import fft_input_pairer_pkg::*;

    localparam int N    = 8;
    localparam int H    = N / 2;
    localparam int RING = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_input_pairer_if b0();
    fft_input_pairer_if b1();

    fft_input_pairer #(.N(N), .OUT_GAP(0))  u_dut0 (.clk(clk), .reset(rst), .bus(b0));
    fft_input_pairer #(.N(N), .OUT_GAP(12)) u_dut1 (.clk(clk), .reset(rst), .bus(b1));

    // Stimulus: one driver, routed to the selected instance.
    logic             drv_valid = 1'b0;
    logic             drv_sof   = 1'b0;
    complex_product_t drv_data  = '0;
    int               sel       = 0;

    assign b0.in_valid = drv_valid && (sel == 0);
    assign b0.in_sof   = drv_sof;
    assign b0.in_data  = drv_data;
    assign b1.in_valid = drv_valid && (sel == 1);
    assign b1.in_sof   = drv_sof;
    assign b1.in_data  = drv_data;

    logic             o_en [2];
    logic             o_sof[2];
    logic             o_err[2];
    logic             o_rdy[2];
    logic             i_val[2];
    complex_product_t o_d0 [2];
    complex_product_t o_d1 [2];

    assign o_en[0]  = b0.out_enable;  assign o_en[1]  = b1.out_enable;
    assign o_sof[0] = b0.out_sof;     assign o_sof[1] = b1.out_sof;
    assign o_err[0] = b0.err_sof;     assign o_err[1] = b1.err_sof;
    assign o_rdy[0] = b0.in_ready;    assign o_rdy[1] = b1.in_ready;
    assign i_val[0] = b0.in_valid;    assign i_val[1] = b1.in_valid;
    assign o_d0[0]  = b0.data_0;      assign o_d0[1]  = b1.data_0;
    assign o_d1[0]  = b0.data_1;      assign o_d1[1]  = b1.data_1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: completed frames with their scheduled first-pair cycle.
    complex_product_t fsmp [2][RING][N];
    int               fs   [2][RING];
    int               hd[2], tl[2], cnt[2], pcnt[2], last_e[2];
    complex_product_t part [2][N];
    bit               merr[2];

    int checks   = 0;
    int failures = 0;

    bit lit_on   = 1'b0;
    int lit_base = 0;
    int lit_n    = 0;
    bit drv_to   = 1'b0;
    bit done_req = 1'b0;

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit               ee;
        int               k;
        int               lv;
        int               g;
        int               s;
        if (cyc > 60000) begin
            failures++;
            $display("FAIL watchdog actual=%0d expected<=60000", cyc);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
        for (int d = 0; d < 2; d++) begin
            g = (d == 0) ? 0 : 12;
            if (cyc >= 1) begin
                ee = 1'b0;
                k  = 0;
                if (cnt[d] > 0 && fs[d][hd[d]] <= cyc) begin
                    ee = 1'b1;
                    k  = cyc - fs[d][hd[d]];
                end
                chk("out_enable", d, 64'(o_en[d]), 64'(ee));
                if (ee) begin
                    chk("data_0", d, {32'b0, o_d0[d]}, {32'b0, fsmp[d][hd[d]][k]});
                    chk("data_1", d, {32'b0, o_d1[d]}, {32'b0, fsmp[d][hd[d]][k + H]});
                    chk("out_sof", d, 64'(o_sof[d]), 64'(k == 0));
                    if (k == H - 1) begin
                        hd[d]  = (hd[d] + 1) % RING;
                        cnt[d] = cnt[d] - 1;
                    end
                end else begin
                    chk("out_sof_idle", d, 64'(o_sof[d]), 64'(0));
                end
                chk("in_ready", d, 64'(o_rdy[d]), 64'(cnt[d] < 2));
                chk("err_sof", d, 64'(o_err[d]), 64'(merr[d]));
                if (lit_on && d == sel && o_en[d] === 1'b1) begin
                    lv = lit_base + 8 * (lit_n / 4) + lit_n % 4;
                    chk("lit_d0_re", d, {48'b0, o_d0[d].re}, {48'b0, 16'(lv)});
                    chk("lit_d1_re", d, {48'b0, o_d1[d].re}, {48'b0, 16'(lv + 4)});
                    chk("lit_d0_im", d, {48'b0, o_d0[d].im}, {48'b0, 16'(-lv)});
                    lit_n++;
                end
            end
            // Advance the model by what happens at the coming rising edge.
            if (rst) begin
                cnt[d] = 0; hd[d] = 0; tl[d] = 0; pcnt[d] = 0;
                merr[d] = 1'b0; last_e[d] = -1000;
            end else if (i_val[d] && o_rdy[d]) begin
                if (drv_sof && pcnt[d] != 0) begin
                    merr[d]    = 1'b1;
                    part[d][0] = drv_data;
                    pcnt[d]    = 1;
                end else begin
                    part[d][pcnt[d]] = drv_data;
                    pcnt[d]++;
                    if (pcnt[d] == N) begin
                        // Earliest is 2 edges after the last accept, and at
                        // least g idle cycles after the previous frame's last pair.
                        s = cyc + 3;
                        if (last_e[d] + g + 1 > s) s = last_e[d] + g + 1;
                        fs[d][tl[d]] = s;
                        for (int j = 0; j < N; j++) fsmp[d][tl[d]][j] = part[d][j];
                        last_e[d] = s + H - 1;
                        tl[d]     = (tl[d] + 1) % RING;
                        cnt[d]    = cnt[d] + 1;
                        pcnt[d]   = 0;
                    end
                end
            end
        end
        if (!lit_on) lit_n = 0;
        if (done_req) begin
            for (int d = 0; d < 2; d++) chk("pending_pairs", d, 64'(cnt[d]), 64'(0));
            chk("driver_timeout", 0, 64'(drv_to), 64'(0));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic idle(input int n);
        drv_valid = 1'b0;
        drv_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_raw(input complex_product_t v, input bit sof);
        bit acc;
        int guard;
        acc       = 1'b0;
        guard     = 0;
        drv_valid = 1'b1;
        drv_sof   = sof;
        drv_data  = v;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = (sel == 0) ? b0.in_ready : b1.in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) drv_to = 1'b1;
    endtask

    task automatic send(input int re, input bit sof);
        complex_product_t v;
        v.re = 16'(re);
        v.im = 16'(-re);
        send_raw(v, sof);
    endtask

    task automatic end_phase(input int n);
        idle(n);
        lit_on = 1'b0;
        idle(1);
    endtask

    initial begin
        int guard;
        complex_product_t v;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single frame 0..7
        sel = 0; lit_base = 0; lit_on = 1'b1;
        for (int i = 0; i < 8; i++) send(i, i == 0);
        end_phase(20);

        // Three back-to-back frames 0..23
        lit_on = 1'b1;
        for (int i = 0; i < 24; i++) send(i, (i % 8) == 0);
        end_phase(20);

        // Four frames into the OUT_GAP=12 instance: forces backpressure
        sel = 1; lit_on = 1'b1;
        for (int i = 0; i < 32; i++) send(i, (i % 8) == 0);
        end_phase(100);

        // Mid-frame SOF realignment
        sel = 0; lit_base = 100; lit_on = 1'b1;
        for (int i = 0; i < 5; i++) send(i, i == 0);
        send(100, 1'b1);
        for (int i = 101; i < 108; i++) send(i, 1'b0);
        end_phase(20);

        // Valid toggling every other cycle
        lit_base = 200; lit_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(200 + i, i == 0);
            idle(1);
        end
        end_phase(20);

        // Reset right after pair (1,5)
        for (int i = 0; i < 8; i++) send(i, i == 0);
        idle(0);
        drv_valid = 1'b0;
        guard = 0;
        while (!(b0.out_enable === 1'b1 && b0.data_0.re == 16'sd1) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) drv_to = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lit_base = 50; lit_on = 1'b1;
        for (int i = 0; i < 8; i++) send(50 + i, i == 0);
        end_phase(20);

        // Randomized traffic across both instances
        for (int b = 0; b < 20; b++) begin
            sel = int'($urandom_range(0, 1));
            for (int j = 0; j < 16; j++) begin
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                v.re = 16'($urandom);
                v.im = 16'($urandom);
                send_raw(v, $urandom_range(0, 9) == 0);
            end
        end
        idle(150);
        done_req = 1'b1;
    end

endmodule
`default_nettype wire
